// File: rtl/mem_responder_if.sv
// Load/store request and response bundle between the datapath (master) and memory (slave).
interface mem_responder_if;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed memory responder: one request at a time, response strobe LATENCY cycles after acceptance.
// req_ready is high only in IDLE; requests presented in WAIT/RESP wait until IDLE.
module mem_responder #(
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 3
) (
  input logic            clk,
  input logic            reset,
  mem_responder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam int DEPTH = 1 << ADDR_BITS;

  state_t               state_q, state_d;
  logic [3:0]           countdown_q, countdown_d;
  logic                 we_q, we_d;
  logic [31:0]          addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic [31:0]          mem_q [DEPTH];

  logic                 commit;
  logic                 cur_we;
  logic                 cur_err;
  logic                 mem_we;
  logic [31:0]          cur_addr;
  logic [31:0]          cur_wdata;
  logic [ADDR_BITS-1:0] cur_idx;

  always_comb begin
    state_d     = state_q;
    countdown_d = countdown_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = '0;
    err_d       = 1'b0;
    commit      = 1'b0;
    cur_we      = we_q;
    cur_addr    = addr_q;
    cur_wdata   = wdata_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          // With single-cycle latency the commit happens on the acceptance edge itself.
          cur_we    = bus.req_we;
          cur_addr  = bus.req_addr;
          cur_wdata = bus.req_wdata;
          if (LATENCY == 1) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            countdown_d = 4'(LATENCY - 2);
            state_d     = WAIT;
          end
        end
      end
      WAIT: begin
        if (countdown_q == 4'd0) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          countdown_d = countdown_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    cur_idx = cur_addr[ADDR_BITS+1:2];
    cur_err = (cur_addr[1:0] != 2'b00) || ((cur_addr >> (ADDR_BITS + 2)) != 32'd0);
    mem_we  = commit && cur_we && !cur_err;
    if (commit) begin
      err_d = cur_err;
      if (!cur_we && !cur_err) begin
        rdata_d = mem_q[cur_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      countdown_q <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      countdown_q <= countdown_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  // Storage is not reset; an aborted store never reaches its commit edge.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[cur_idx] <= cur_wdata;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a LATENCY=3 instance for most scenarios, a LATENCY=1 instance for the fast build.
module tb_mem_responder;
  logic clk;
  logic reset;
  int   tests;
  int   fails;

  mem_responder_if m3 ();
  mem_responder_if m1 ();

  mem_responder #(.ADDR_BITS(8), .LATENCY(3)) dut3 (.clk(clk), .reset(reset), .bus(m3));
  mem_responder #(.ADDR_BITS(8), .LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(m1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input bit sel, input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
    if (sel) begin
      m1.req_valid = v; m1.req_we = we; m1.req_addr = a; m1.req_wdata = d;
    end else begin
      m3.req_valid = v; m3.req_we = we; m3.req_addr = a; m3.req_wdata = d;
    end
  endtask

  function automatic logic get_ready(input bit sel);
    return sel ? m1.req_ready : m3.req_ready;
  endfunction

  function automatic logic get_valid(input bit sel);
    return sel ? m1.resp_valid : m3.resp_valid;
  endfunction

  // lat = edges after the acceptance edge before resp_valid is seen (LATENCY-1 expected).
  task automatic do_req(input bit sel, input logic we, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output int lat);
    int n;
    n = 0;
    while (!get_ready(sel) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    drive(sel, 1'b1, we, a, d);
    @(posedge clk); #1;
    drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
    lat = -1;
    rd  = '0;
    er  = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (get_valid(sel)) begin
        lat = k;
        rd  = sel ? m1.resp_rdata : m3.resp_rdata;
        er  = sel ? m1.resp_err : m3.resp_err;
        break;
      end
      @(posedge clk); #1;
    end
    if (lat < 0) begin
      tests++; fails++;
      $display("FAIL req_timeout addr=%h: no resp_valid within 20 cycles", a);
    end else begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({m3.req_ready, m3.resp_valid, m3.resp_err, m3.resp_rdata} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      fails++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b err=%b rd=%h want 1 0 0 0",
               m3.req_ready, m3.resp_valid, m3.resp_err, m3.resp_rdata);
    end
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      tests++;
      if ({m3.req_ready, m3.resp_valid, m3.resp_err, m3.resp_rdata} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
        fails++;
        $display("FAIL idle_outputs[%0d]: got rdy=%b vld=%b err=%b rd=%h want 1 0 0 0",
                 k, m3.req_ready, m3.resp_valid, m3.resp_err, m3.resp_rdata);
      end
    end
  endtask

  task automatic test_store_load();
    logic [31:0] rd;
    logic        er;
    int          lat;
    do_req(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, rd, er, lat);
    tests++;
    if (lat !== 2 || rd !== 32'h0 || er !== 1'b0) begin
      fails++;
      $display("FAIL store_resp: got lat=%0d rd=%h err=%b want lat=2 rd=0 err=0", lat, rd, er);
    end
    do_req(0, 1'b0, 32'h0000_0010, 32'h0, rd, er, lat);
    tests++;
    if (lat !== 2 || rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
      fails++;
      $display("FAIL load_resp: got lat=%0d rd=%h err=%b want lat=2 rd=deadbeef err=0", lat, rd, er);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    logic        er;
    int          lat;
    do_req(0, 1'b1, 32'h0000_0000, 32'h0BAD_F00D, rd, er, lat);
    do_req(0, 1'b0, 32'h0000_0012, 32'h0, rd, er, lat);
    tests++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      fails++;
      $display("FAIL misaligned_load: got rd=%h err=%b want rd=0 err=1", rd, er);
    end
    do_req(0, 1'b1, 32'h0000_0400, 32'hFFFF_FFFF, rd, er, lat);
    tests++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      fails++;
      $display("FAIL range_store: got rd=%h err=%b want rd=0 err=1", rd, er);
    end
    do_req(0, 1'b0, 32'h0000_0000, 32'h0, rd, er, lat);
    tests++;
    if (rd !== 32'h0BAD_F00D || er !== 1'b0) begin
      fails++;
      $display("FAIL word0_intact: got rd=%h err=%b want rd=0badf00d err=0", rd, er);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [31:0] addrs [3];
    logic [31:0] vals  [3];
    logic [31:0] got   [3];
    int          acc   [3];
    int          n_acc;
    int          n_resp;
    addrs[0] = 32'h4;         addrs[1] = 32'h8;         addrs[2] = 32'hC;
    vals[0]  = 32'h1111_0004; vals[1]  = 32'h2222_0008; vals[2]  = 32'h3333_000C;
    for (int i = 0; i < 3; i++) begin
      do_req(0, 1'b1, addrs[i], vals[i], rd, er, lat);
      got[i] = 32'h0;
      acc[i] = 0;
    end
    n_acc  = 0;
    n_resp = 0;
    drive(0, 1'b1, 1'b0, addrs[0], 32'h0);
    for (int k = 0; k < 20; k++) begin
      if (m3.resp_valid) begin
        if (n_resp < 3) got[n_resp] = m3.resp_rdata;
        n_resp++;
      end
      if (n_acc > 0 && k >= acc[n_acc-1] && k <= acc[n_acc-1] + 2) begin
        tests++;
        if (m3.req_ready !== 1'b0) begin
          fails++;
          $display("FAIL b2b_ready_low[%0d]: got %b want 0", k, m3.req_ready);
        end
      end
      if (m3.req_ready && n_acc < 3) begin
        m3.req_addr = addrs[n_acc];
        acc[n_acc]  = k + 1;
        n_acc++;
      end
      @(posedge clk); #1;
      if (n_acc == 3 && k + 1 == acc[2]) m3.req_valid = 1'b0;
    end
    tests++;
    if (n_acc !== 3 || acc[1] - acc[0] !== 4 || acc[2] - acc[1] !== 4) begin
      fails++;
      $display("FAIL b2b_spacing: got n=%0d gaps %0d %0d want 3 accepts gaps 4 4",
               n_acc, acc[1] - acc[0], acc[2] - acc[1]);
    end
    tests++;
    if (n_resp !== 3) begin
      fails++;
      $display("FAIL b2b_pulses: got %0d want 3", n_resp);
    end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (got[i] !== vals[i]) begin
        fails++;
        $display("FAIL b2b_data[%0d]: got %h want %h", i, got[i], vals[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          pulses;
    do_req(0, 1'b1, 32'h0000_0020, 32'hCAFE_0001, rd, er, lat);
    pulses = 0;
    drive(0, 1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    tests++;
    if (m3.req_ready !== 1'b1 || m3.resp_valid !== 1'b0) begin
      fails++;
      $display("FAIL midreset_idle: got rdy=%b vld=%b want 1 0", m3.req_ready, m3.resp_valid);
    end
    for (int k = 0; k < 6; k++) begin
      if (k == 3) reset = 1'b1;
      @(posedge clk); #1;
      if (m3.resp_valid) pulses++;
    end
    tests++;
    if (pulses !== 0) begin
      fails++;
      $display("FAIL midreset_pulse: got %0d pulses want 0", pulses);
    end
    do_req(0, 1'b0, 32'h0000_0020, 32'h0, rd, er, lat);
    tests++;
    if (rd !== 32'hCAFE_0001 || er !== 1'b0) begin
      fails++;
      $display("FAIL midreset_mem: got rd=%h err=%b want cafe0001 0", rd, er);
    end
  endtask

  task automatic test_latency1();
    logic [31:0] rd;
    logic        er;
    int          lat;
    do_req(1, 1'b1, 32'h0000_0000, 32'hA5A5_A5A5, rd, er, lat);
    tests++;
    if (lat !== 0 || er !== 1'b0) begin
      fails++;
      $display("FAIL lat1_store: got lat=%0d err=%b want lat=0 err=0", lat, er);
    end
    do_req(1, 1'b0, 32'h0000_0000, 32'h0, rd, er, lat);
    tests++;
    if (lat !== 0 || rd !== 32'hA5A5_A5A5) begin
      fails++;
      $display("FAIL lat1_load: got lat=%0d rd=%h want lat=0 rd=a5a5a5a5", lat, rd);
    end
    tests++;
    if (m1.resp_valid !== 1'b0 || m1.resp_rdata !== 32'h0) begin
      fails++;
      $display("FAIL lat1_single_pulse: got vld=%b rd=%h want 0 0", m1.resp_valid, m1.resp_rdata);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_store_load();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    test_latency1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
